// File: rtl/pipe_ctrl_unit.sv
// Staged, hazard-aware control path for the 5-stage RV32I core.
// Optional sticky illegal-opcode flag: define PIPE_CTRL_ILLEGAL_TRAP_EN.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 3,
    parameter int WB_SEL_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            opcode_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  stall_ext,
    input  logic                  flush_ex,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  hazard_stall,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_mem_write,
    output logic                  mem_mem_read,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_reg_write,
    output logic [WB_SEL_W-1:0]   wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  illegal_seen
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [WB_SEL_W-1:0]   mem_to_reg;
        logic [ALU_OP_W-1:0]   alu_op;
        logic                  alu_src;
        logic                  branch;
        logic                  jump;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [WB_SEL_W-1:0]   mem_to_reg;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic                  reg_write;
        logic [WB_SEL_W-1:0]   mem_to_reg;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    id_ex_t  dec, id_ex_d, id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;
    logic    legal, uses_rs1, uses_rs2, ld_hit;

    always_comb begin
        dec      = '0;
        legal    = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode_id)
            OP_R: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_SEL_W'(3'b010);
                dec.alu_op     = ALU_OP_W'(3'b010);
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_I: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_SEL_W'(3'b110);
                dec.alu_op     = ALU_OP_W'(3'b011);
                dec.alu_src    = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = WB_SEL_W'(3'b011);
                dec.alu_src    = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write  = 1'b1;
                dec.mem_to_reg = WB_SEL_W'(3'b010);
                dec.alu_src    = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_BEQ: begin
                dec.mem_to_reg = WB_SEL_W'(3'b010);
                dec.alu_op     = ALU_OP_W'(3'b001);
                dec.branch     = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_SEL_W'(3'b100);
                dec.alu_op     = ALU_OP_W'(3'b100);
                dec.alu_src    = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_SEL_W'(3'b001);
                dec.alu_op     = ALU_OP_W'(3'b100);
                dec.alu_src    = 1'b1;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                uses_rs1      = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // illegal opcodes decode to a full bubble, rd included
        if (legal) dec.rd = rd_id;
        if (rd_id == '0) dec.reg_write = 1'b0;
    end

    assign ld_hit = id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                    ((uses_rs1 && (id_ex_q.rd == rs1_id)) ||
                     (uses_rs2 && (id_ex_q.rd == rs2_id)));

    assign hazard_stall = ld_hit && !flush_ex;
    assign pc_write     = !(hazard_stall || stall_ext);
    assign if_id_write  = pc_write;

    always_comb begin
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        if (!stall_ext) begin
            if (flush_ex || hazard_stall) id_ex_d = '0;
            else                          id_ex_d = dec;
            ex_mem_d.reg_write  = id_ex_q.reg_write;
            ex_mem_d.mem_read   = id_ex_q.mem_read;
            ex_mem_d.mem_write  = id_ex_q.mem_write;
            ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
            ex_mem_d.rd         = id_ex_q.rd;
            mem_wb_d.reg_write  = ex_mem_q.reg_write;
            mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
            mem_wb_d.rd         = ex_mem_q.rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign ex_alu_op     = id_ex_q.alu_op;
    assign ex_alu_src    = id_ex_q.alu_src;
    assign ex_branch     = id_ex_q.branch;
    assign ex_jump       = id_ex_q.jump;
    assign ex_rd         = id_ex_q.rd;
    assign mem_mem_write = ex_mem_q.mem_write;
    assign mem_mem_read  = ex_mem_q.mem_read;
    assign mem_rd        = ex_mem_q.rd;
    assign wb_reg_write  = mem_wb_q.reg_write;
    assign wb_mem_to_reg = mem_wb_q.mem_to_reg;
    assign wb_rd         = mem_wb_q.rd;

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q ||
                       (!stall_ext && !flush_ex && !hazard_stall && !legal);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) illegal_q <= 1'b0;
        else          illegal_q <= illegal_d;
    end

    assign illegal_seen = illegal_q;
`else
    assign illegal_seen = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode latency, load-use,
// flush priority, external stall and the illegal-opcode flag.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    // ex_v = {alu_op, alu_src, branch, jump, rd}
    localparam logic [10:0] EX_NOP = {3'b011, 1'b1, 1'b0, 1'b0, 5'd0};

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] opcode_id;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       stall_ext, flush_ex;
    logic       pc_write, if_id_write, hazard_stall;
    logic [2:0] ex_alu_op;
    logic       ex_alu_src, ex_branch, ex_jump;
    logic [4:0] ex_rd;
    logic       mem_mem_write, mem_mem_read;
    logic [4:0] mem_rd;
    logic       wb_reg_write;
    logic [2:0] wb_mem_to_reg;
    logic [4:0] wb_rd;
    logic       illegal_seen;

    int checks = 0;
    int errors = 0;

    logic [10:0] ex_v;
    logic [6:0]  mem_v;
    logic [8:0]  wb_v;
    logic [2:0]  ctl_v;

    assign ex_v  = {ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_rd};
    assign mem_v = {mem_mem_write, mem_mem_read, mem_rd};
    assign wb_v  = {wb_reg_write, wb_mem_to_reg, wb_rd};
    assign ctl_v = {pc_write, if_id_write, hazard_stall};

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode_id     (opcode_id),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rd_id         (rd_id),
        .stall_ext     (stall_ext),
        .flush_ex      (flush_ex),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .hazard_stall  (hazard_stall),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_rd         (ex_rd),
        .mem_mem_write (mem_mem_write),
        .mem_mem_read  (mem_mem_read),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_rd         (wb_rd),
        .illegal_seen  (illegal_seen)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd);
        opcode_id = op;
        rs1_id    = r1;
        rs2_id    = r2;
        rd_id     = rd;
        #1;
    endtask

    task automatic set_nop();
        set_in(OP_I, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stall_ext = 1'b0;
        flush_ex = 1'b0;
        set_in(OP_R, 5'd1, 5'd2, 5'd5);
        tick();
        tick();
        checks++;
        if (ex_v !== 11'd0) begin
            errors++;
            $display("FAIL rst_ex got %h exp %h", ex_v, 11'd0);
        end
        checks++;
        if (mem_v !== 7'd0 || wb_v !== 9'd0) begin
            errors++;
            $display("FAIL rst_memwb got %h/%h exp 0/0", mem_v, wb_v);
        end
        checks++;
        if (ctl_v !== 3'b110 || illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctl got %b/%b exp 110/0", ctl_v, illegal_seen);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (ex_v !== {3'b010, 3'b000, 5'd5}) begin
            errors++;
            $display("FAIL r_in_ex got %h exp %h", ex_v, {3'b010, 3'b000, 5'd5});
        end
        set_nop();
        reset_n = 1'b0;
        #1;
        checks++;
        if (ex_v !== 11'd0 || mem_v !== 7'd0) begin
            errors++;
            $display("FAIL async_rst got %h/%h exp 0/0", ex_v, mem_v);
        end
        reset_n = 1'b1;
        tick();
        set_in(OP_R, 5'd1, 5'd2, 5'd5);
        tick();
        set_nop();
        tick();
        checks++;
        if (mem_v !== {2'b00, 5'd5}) begin
            errors++;
            $display("FAIL r_in_mem got %h exp %h", mem_v, {2'b00, 5'd5});
        end
        tick();
        checks++;
        if (wb_v !== {1'b1, 3'b010, 5'd5}) begin
            errors++;
            $display("FAIL r_in_wb got %h exp %h", wb_v, {1'b1, 3'b010, 5'd5});
        end
    endtask

    task automatic test_load_use();
        set_in(OP_LOAD, 5'd1, 5'd0, 5'd3);
        tick();
        checks++;
        if (ex_v !== {3'b000, 3'b100, 5'd3}) begin
            errors++;
            $display("FAIL ld_in_ex got %h exp %h", ex_v, {3'b000, 3'b100, 5'd3});
        end
        set_in(OP_R, 5'd3, 5'd2, 5'd6);
        checks++;
        if (ctl_v !== 3'b001) begin
            errors++;
            $display("FAIL lu_stall got %b exp 001", ctl_v);
        end
        tick();
        checks++;
        if (ex_v !== 11'd0 || mem_v !== {2'b01, 5'd3}) begin
            errors++;
            $display("FAIL lu_bubble got %h/%h exp 0/%h", ex_v, mem_v, {2'b01, 5'd3});
        end
        checks++;
        if (ctl_v !== 3'b110) begin
            errors++;
            $display("FAIL lu_release got %b exp 110", ctl_v);
        end
        tick();
        checks++;
        if (ex_v !== {3'b010, 3'b000, 5'd6}) begin
            errors++;
            $display("FAIL lu_add_ex got %h exp %h", ex_v, {3'b010, 3'b000, 5'd6});
        end
        checks++;
        if (wb_v !== {1'b1, 3'b011, 5'd3} || mem_v !== 7'd0) begin
            errors++;
            $display("FAIL lu_ld_wb got %h/%h exp %h/0", wb_v, mem_v, {1'b1, 3'b011, 5'd3});
        end
    endtask

    task automatic test_exemptions();
        set_in(OP_LOAD, 5'd1, 5'd0, 5'd0);
        tick();
        set_in(OP_R, 5'd0, 5'd0, 5'd7);
        checks++;
        if (ctl_v !== 3'b110) begin
            errors++;
            $display("FAIL ex_rd0 got %b exp 110", ctl_v);
        end
        tick();
        checks++;
        if (ex_v !== {3'b010, 3'b000, 5'd7}) begin
            errors++;
            $display("FAIL ex_rd0_add got %h exp %h", ex_v, {3'b010, 3'b000, 5'd7});
        end
        set_in(OP_LOAD, 5'd1, 5'd0, 5'd4);
        tick();
        set_in(OP_LUI, 5'd4, 5'd4, 5'd4);
        checks++;
        if (ctl_v !== 3'b110) begin
            errors++;
            $display("FAIL ex_lui got %b exp 110", ctl_v);
        end
        tick();
        checks++;
        if (ex_v !== {3'b100, 3'b100, 5'd4} || wb_v !== {1'b1, 3'b010, 5'd7}) begin
            errors++;
            $display("FAIL ex_lui_pipe got %h/%h exp %h/%h", ex_v, wb_v,
                     {3'b100, 3'b100, 5'd4}, {1'b1, 3'b010, 5'd7});
        end
    endtask

    task automatic test_flush();
        set_in(OP_LOAD, 5'd1, 5'd0, 5'd8);
        tick();
        set_in(OP_R, 5'd8, 5'd1, 5'd9);
        checks++;
        if (ctl_v !== 3'b001) begin
            errors++;
            $display("FAIL fl_pre got %b exp 001", ctl_v);
        end
        flush_ex = 1'b1;
        #1;
        checks++;
        if (ctl_v !== 3'b110) begin
            errors++;
            $display("FAIL fl_mask got %b exp 110", ctl_v);
        end
        tick();
        flush_ex = 1'b0;
        checks++;
        if (ex_v !== 11'd0) begin
            errors++;
            $display("FAIL fl_bubble got %h exp 0", ex_v);
        end
        checks++;
        if (mem_v !== {2'b01, 5'd8} || wb_v !== {1'b1, 3'b100, 5'd4}) begin
            errors++;
            $display("FAIL fl_memwb got %h/%h exp %h/%h", mem_v, wb_v,
                     {2'b01, 5'd8}, {1'b1, 3'b100, 5'd4});
        end
    endtask

    task automatic test_stall_ext();
        set_in(OP_JALR, 5'd2, 5'd0, 5'd1);
        tick();
        checks++;
        if (ex_v !== {3'b000, 3'b101, 5'd1}) begin
            errors++;
            $display("FAIL jalr_ex got %h exp %h", ex_v, {3'b000, 3'b101, 5'd1});
        end
        stall_ext = 1'b1;
        set_in(OP_R, 5'd1, 5'd2, 5'd10);
        checks++;
        if (ctl_v !== 3'b000) begin
            errors++;
            $display("FAIL st_ctl got %b exp 000", ctl_v);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ex_v !== {3'b000, 3'b101, 5'd1} || mem_v !== 7'd0 ||
                wb_v !== {1'b1, 3'b011, 5'd8}) begin
                errors++;
                $display("FAIL st_hold%0d got %h/%h/%h exp %h/0/%h", i, ex_v, mem_v,
                         wb_v, {3'b000, 3'b101, 5'd1}, {1'b1, 3'b011, 5'd8});
            end
        end
        stall_ext = 1'b0;
        set_nop();
        tick();
        checks++;
        if (ex_v !== EX_NOP || mem_v !== {2'b00, 5'd1} || wb_v !== 9'd0) begin
            errors++;
            $display("FAIL st_resume got %h/%h/%h exp %h/%h/0", ex_v, mem_v, wb_v,
                     EX_NOP, {2'b00, 5'd1});
        end
        tick();
        checks++;
        if (wb_v !== {1'b1, 3'b000, 5'd1}) begin
            errors++;
            $display("FAIL jalr_wb got %h exp %h", wb_v, {1'b1, 3'b000, 5'd1});
        end
    endtask

    task automatic test_illegal();
        logic exp_ill;
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        checks++;
        if (illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL ill_pre got %b exp 0", illegal_seen);
        end
        set_in(OP_BAD, 5'd1, 5'd2, 5'd9);
        tick();
        checks++;
        if (ex_v !== 11'd0 || illegal_seen !== exp_ill) begin
            errors++;
            $display("FAIL ill_set got %h/%b exp 0/%b", ex_v, illegal_seen, exp_ill);
        end
        set_nop();
        tick();
        tick();
        checks++;
        if (illegal_seen !== exp_ill || ex_v !== EX_NOP) begin
            errors++;
            $display("FAIL ill_sticky got %b/%h exp %b/%h", illegal_seen, ex_v,
                     exp_ill, EX_NOP);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (illegal_seen !== 1'b0 || ex_v !== 11'd0) begin
            errors++;
            $display("FAIL ill_rst got %b/%h exp 0/0", illegal_seen, ex_v);
        end
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_exemptions();
        test_flush();
        test_stall_ext();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined control path for the 5-stage RV32I core.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and applies stall, bubble and flush.
- Replaces the purely combinational decoder with staged, hazard-aware control, and adds JALR.

Parameters:
REG_ADDR_W, 5, register index width
ALU_OP_W, 3, alu_op field width
WB_SEL_W, 3, mem_to_reg (writeback select) width

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
opcode_id  in  7  instruction[6:0] in ID
rs1_id  in  REG_ADDR_W  source 1 index in ID
rs2_id  in  REG_ADDR_W  source 2 index in ID
rd_id  in  REG_ADDR_W  destination index in ID
stall_ext  in  1  external freeze (memory wait); holds all stages
flush_ex  in  1  branch/jump taken, resolved in EX; kills the ID instruction
pc_write  out  1  PC enable
if_id_write  out  1  IF/ID register enable
hazard_stall  out  1  load-use stall active
ex_alu_op  out  ALU_OP_W  EX-stage ALU op
ex_alu_src  out  1  EX-stage immediate select
ex_branch  out  1  EX-stage conditional branch
ex_jump  out  1  EX-stage JAL/JALR
ex_rd  out  REG_ADDR_W  EX-stage destination
mem_mem_write  out  1  MEM-stage store enable
mem_mem_read  out  1  MEM-stage load enable
mem_rd  out  REG_ADDR_W  MEM-stage destination
wb_reg_write  out  1  WB-stage register write
wb_mem_to_reg  out  WB_SEL_W  WB-stage writeback select
wb_rd  out  REG_ADDR_W  WB-stage destination
illegal_seen  out  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Decode (combinational, ID), as {reg_write, mem_read, mem_write, mem_to_reg, alu_op, alu_src, branch, jump}:
  - R 0110011: 1,0,0,010,010,0,0,0
  - I 0010011: 1,0,0,110,011,1,0,0
  - Load 0000011: 1,1,0,011,000,1,0,0
  - Store 0100011: 0,0,1,010,000,1,0,0
  - BEQ 1100011: 0,0,0,010,001,0,1,0
  - LUI 0110111: 1,0,0,100,100,1,0,0
  - AUIPC 0010111: 1,0,0,001,100,1,0,0
  - JAL 1101111: 1,0,0,000,000,1,0,1
  - JALR 1100111: 1,0,0,000,000,1,0,1
  - Any other opcode: all zero (bubble).
- reg_write is forced to 0 when rd_id==0.
- Source usage:
  - uses_rs1 = R, I, Load, Store, BEQ, JALR.
  - uses_rs2 = R, Store, BEQ.
- Load-use hazard: hazard_stall = ex_mem_read && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1_id) || (uses_rs2 && ex_rd==rs2_id)). Combinational from the ID/EX register and ID inputs.
- pc_write = if_id_write = !(hazard_stall || stall_ext).
- ID/EX update at posedge, in priority order:
  1. stall_ext: hold.
  2. flush_ex: load bubble.
  3. hazard_stall: load bubble.
  4. Otherwise: load the decoded bundle.
- flush_ex masks hazard_stall: when flush_ex=1, hazard_stall=0.
- EX/MEM and MEM/WB: advance every cycle; hold when stall_ext=1. flush_ex does not affect EX/MEM or MEM/WB.
- Latency: an instruction decoded at cycle n appears on ex_* at n+1, mem_* at n+2, wb_* at n+3.
- A load-use stall inserts exactly one bubble. The dependent instruction re-decodes the next cycle with no hazard, because the load has moved to MEM.
- Bubble = all control bits 0, rd 0.
- Reset (async assert, sync deassert handled by the top): all stage registers clear to bubble.
  - All ex_/mem_/wb_ outputs read 0.
  - pc_write=1, if_id_write=1, hazard_stall=0, illegal_seen=0.
- Reset asserted mid-stall: all registers clear immediately; the stall is abandoned.

Optional Feature:
Macro PIPE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An opcode outside the decode list, entering ID/EX with no stall/flush/hazard, sets illegal_seen at that edge.
  - illegal_seen is sticky until reset.
  - The ID/EX register still loads a bubble for that opcode.
- Undefined: illegal_seen is tied to 0 and no flag flop exists.

Test Plan:
- Reset: reset_n=0 mid-stream with opcode_id=0110011 -> all stage outputs 0, pc_write=1. After release, R-type rd=5 -> wb_reg_write=1, wb_mem_to_reg=010, wb_rd=5 three cycles later.
- Load-use: Load rd=3, then ADD rs1=3 -> hazard_stall=1 for 1 cycle, pc_write=0, ex_* bubble for 1 cycle, then ADD in EX with ex_alu_op=010.
- Hazard exemptions:
  - Load rd=0 then ADD rs1=0 -> no stall.
  - Load rd=4 then LUI rd=4 -> no stall (LUI uses no sources).
- Flush priority: flush_ex=1 together with a load-use hazard -> hazard_stall=0; next ex_* bubble; MEM/WB unaffected.
- External stall: stall_ext=1 for 3 cycles during a JALR rd=1 in EX -> ex_jump=1 held 3 cycles, wb_* held; JALR reaches WB with wb_mem_to_reg=000 after release.
- Illegal opcode: opcode_id=1111111 -> ex_* bubble. With PIPE_CTRL_ILLEGAL_TRAP_EN, illegal_seen=1 next cycle and stays 1 until reset_n=0. Without the macro, illegal_seen stays 0.
